div_input_ctrl: RTL and testbench

DIV_INPUT_CTRL -- requirements
Module: div_input_ctrl

---
 rtl/div_input_ctrl.sv | 130 +++++++++++++
 tb/tb_div_input_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_input_ctrl.sv
// Synchronizes and debounces the go button and switch operands, then issues one registered start to the divider per press.
// Clean press to start: DB_COUNT+3 edges; the request holds start/busy and operands stable until div_finish.
module div_input_ctrl #(
   parameter int DB_COUNT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_go,
   input  logic [3:0] sw_num,
   input  logic [3:0] sw_den,
   input  logic       div_finish,
   output logic       start,
   output logic [3:0] numerador,
   output logic [3:0] denominador,
   output logic       busy,
   output logic       div_by_zero
);

   localparam int CW = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state, state_nxt;
   logic          btn_s1, btn_s2;
   logic [3:0]    num_s1, num_s2, den_s1, den_s2;
   logic [CW-1:0] db_cnt;
   logic          db_level, db_level_d;
   logic          go;
   logic          start_nxt, busy_nxt, dbz_nxt;
   logic [3:0]    num_nxt, den_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         num_s1 <= '0;
         num_s2 <= '0;
         den_s1 <= '0;
         den_s2 <= '0;
      end else begin
         btn_s1 <= btn_go;
         btn_s2 <= btn_s1;
         num_s1 <= sw_num;
         num_s2 <= num_s1;
         den_s1 <= sw_den;
         den_s2 <= den_s1;
      end
   end

   // Level flips only after DB_COUNT consecutive mismatching samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt     <= '0;
         db_level   <= 1'b0;
         db_level_d <= 1'b0;
      end else begin
         db_level_d <= db_level;
         if (btn_s2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            db_level <= ~db_level;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign go = db_level & ~db_level_d;

   always_comb begin
      state_nxt = state;
      start_nxt = start;
      busy_nxt  = busy;
      dbz_nxt   = div_by_zero;
      num_nxt   = numerador;
      den_nxt   = denominador;
      case (state)
         IDLE: begin
            if (go) begin
               num_nxt = num_s2;
               den_nxt = den_s2;
               if (den_s2 != 4'd0) begin
                  state_nxt = REQ;
                  start_nxt = 1'b1;
                  busy_nxt  = 1'b1;
                  dbz_nxt   = 1'b0;
               end else begin
                  state_nxt = DONE;
                  start_nxt = 1'b0;
                  busy_nxt  = 1'b0;
                  dbz_nxt   = 1'b1;
               end
            end
         end
         REQ: begin
            if (div_finish) begin
               state_nxt = DONE;
               start_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end
         end
         DONE: begin
            // Wait for release so a held button cannot retrigger.
            if (!db_level) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         start       <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
         numerador   <= '0;
         denominador <= '0;
      end else begin
         state       <= state_nxt;
         start       <= start_nxt;
         busy        <= busy_nxt;
         div_by_zero <= dbz_nxt;
         numerador   <= num_nxt;
         denominador <= den_nxt;
      end
   end

endmodule

// File: tb/tb_div_input_ctrl.sv
// Directed bench: expected start events are queued by the stimulus and checked by a monitor on each start rising edge.
module tb_div_input_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_go;
   logic [3:0] sw_num, sw_den;
   logic       div_finish;
   logic       start, busy, div_by_zero;
   logic [3:0] numerador, denominador;

   typedef struct {
      logic [3:0] num;
      logic [3:0] den;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic start_q = 1'b0;

   div_input_ctrl #(.DB_COUNT(16)) dut (
      .clk(clk), .rst(rst), .btn_go(btn_go), .sw_num(sw_num), .sw_den(sw_den),
      .div_finish(div_finish), .start(start), .numerador(numerador),
      .denominador(denominador), .busy(busy), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press starts at the next edge; a clean press asserts start after edge 19.
   task automatic press_expect(input logic [3:0] n, input logic [3:0] d);
      exp_t e;
      e.num = n;
      e.den = d;
      e.cyc = cyc + 19;
      exp_q.push_back(e);
      btn_go = 1'b1;
   endtask

   task automatic finish_pulse;
      div_finish = 1'b1;
      tick(1);
      div_finish = 1'b0;
   endtask

   always @(negedge clk) begin
      if (start && !start_q) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_start: start rose at cycle %0d with none expected", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("start_cycle", 8'(cyc), 8'(e.cyc));
            chk("start_num", {4'd0, numerador}, {4'd0, e.num});
            chk("start_den", {4'd0, denominador}, {4'd0, e.den});
            chk("start_busy", {7'd0, busy}, 8'd1);
            chk("start_dbz", {7'd0, div_by_zero}, 8'd0);
         end
      end
      start_q = start;
   end

   initial begin
      int c0;
      rst = 1'b0;
      btn_go = 1'b0;
      sw_num = 4'd0;
      sw_den = 4'd0;
      div_finish = 1'b0;
      tick(3);
      chk("rst_start", {7'd0, start}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_dbz", {7'd0, div_by_zero}, 8'd0);
      chk("rst_operands", {numerador, denominador}, 8'h00);
      rst = 1'b1;
      tick(5);

      // Clean press 8/2, finish at edge 30, button held 40 cycles.
      sw_num = 4'd8;
      sw_den = 4'd2;
      tick(5);
      c0 = cyc;
      press_expect(4'd8, 4'd2);
      tick(29);
      chk("req_hold_start", {7'd0, start}, 8'd1);
      chk("req_hold_num", {4'd0, numerador}, 8'd8);
      div_finish = 1'b1;
      tick(1);
      div_finish = 1'b0;
      chk("finish_edge", 8'(cyc - c0), 8'd30);
      chk("finish_start", {7'd0, start}, 8'd0);
      chk("finish_busy", {7'd0, busy}, 8'd0);
      tick(10);
      btn_go = 1'b0;
      tick(30);

      // Short glitch, then bounce before a stable press.
      sw_num = 4'd7;
      sw_den = 4'd3;
      btn_go = 1'b1;
      tick(10);
      btn_go = 1'b0;
      tick(30);
      chk("glitch_start", {7'd0, start}, 8'd0);
      for (int i = 0; i < 5; i++) begin
         btn_go = 1'b1;
         tick(3);
         btn_go = 1'b0;
         tick(3);
      end
      press_expect(4'd7, 4'd3);
      tick(25);
      finish_pulse();
      tick(4);
      btn_go = 1'b0;
      tick(30);

      // Divide by zero, then a valid divisor.
      sw_num = 4'd8;
      sw_den = 4'd0;
      tick(5);
      btn_go = 1'b1;
      tick(22);
      chk("dbz_flag", {7'd0, div_by_zero}, 8'd1);
      chk("dbz_start", {7'd0, start}, 8'd0);
      chk("dbz_busy", {7'd0, busy}, 8'd0);
      chk("dbz_operands", {numerador, denominador}, 8'h80);
      btn_go = 1'b0;
      tick(30);
      chk("dbz_flag_held", {7'd0, div_by_zero}, 8'd1);
      sw_den = 4'd3;
      tick(5);
      press_expect(4'd8, 4'd3);
      tick(21);
      chk("dbz_cleared", {7'd0, div_by_zero}, 8'd0);
      finish_pulse();
      tick(4);
      btn_go = 1'b0;
      tick(30);

      // Hold through finish, change switches in REQ, then repress.
      sw_num = 4'd8;
      sw_den = 4'd2;
      tick(5);
      press_expect(4'd8, 4'd2);
      tick(22);
      sw_num = 4'd5;
      tick(8);
      chk("switch_ignored", {4'd0, numerador}, 8'd8);
      finish_pulse();
      tick(40);
      chk("held_no_restart", {7'd0, start}, 8'd0);
      chk("held_num", {4'd0, numerador}, 8'd8);
      btn_go = 1'b0;
      tick(20);
      press_expect(4'd5, 4'd2);
      tick(25);
      finish_pulse();
      tick(4);
      btn_go = 1'b0;
      tick(30);

      // Asynchronous reset during REQ with the button still held.
      sw_num = 4'd9;
      sw_den = 4'd4;
      tick(5);
      press_expect(4'd9, 4'd4);
      tick(22);
      chk("pre_reset_start", {7'd0, start}, 8'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_start", {7'd0, start}, 8'd0);
      chk("arst_busy", {7'd0, busy}, 8'd0);
      chk("arst_dbz", {7'd0, div_by_zero}, 8'd0);
      chk("arst_operands", {numerador, denominador}, 8'h00);
      tick(2);
      rst = 1'b1;
      press_expect(4'd9, 4'd4);
      tick(18);
      chk("post_reset_wait", {7'd0, start}, 8'd0);
      tick(7);
      finish_pulse();
      tick(4);
      btn_go = 1'b0;
      tick(30);

      chk("pending_starts", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
